// File: rtl/hwrandom_pkg.sv
// Shared types and helpers for the hwrandom UART array: UART state encoding,
// frame length and baud divider computation.
package hwrandom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int FRAME_BITS = 10;

    function automatic int calcBaudDiv(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/hwrandom_uart_array_if.sv
// Entropy input / UART output bundle of hwrandom_uart_array; the slave side
// is the design, the master side drives raw bits and observes outputs.
interface hwrandom_uart_array_if #(
    parameter int NUM_PORTS = 1
);
    logic                 raw_bit;
    logic                 raw_valid;
    logic [NUM_PORTS-1:0] TxD;
    logic                 health_fail;
    logic [31:0]          disp_word;

    modport master (
        output raw_bit,
        output raw_valid,
        input  TxD,
        input  health_fail,
        input  disp_word
    );

    modport slave (
        input  raw_bit,
        input  raw_valid,
        output TxD,
        output health_fail,
        output disp_word
    );
endinterface

// File: rtl/hwrandom_uart_tx.sv
// Single 8N1 UART transmitter: accepts a byte while idle and shifts it out
// LSB first, one bit every BAUD_DIV clocks.
module hwrandom_uart_tx
    import hwrandom_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_idle,
    output logic       o_txd
);

    localparam int CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int DATA_BITS = FRAME_BITS - 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    uart_state_e      r_state;
    logic [CNT_W-1:0] r_baudCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             w_baudDone;

    assign w_baudDone = (r_baudCnt == CNT_LAST);

    // The line level is registered so a load shows the start bit one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_state   <= START;
                        r_shift   <= i_data;
                        r_baudCnt <= '0;
                        r_bitCnt  <= '0;
                        r_txd     <= 1'b0;
                    end
                end
                START: begin
                    if (w_baudDone) begin
                        r_state   <= DATA;
                        r_baudCnt <= '0;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baudDone) begin
                        r_baudCnt <= '0;
                        if (r_bitCnt == 3'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_txd    <= r_shift[1];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baudDone) begin
                        r_state   <= IDLE;
                        r_baudCnt <= '0;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_idle = (r_state == IDLE);
    assign o_txd  = r_txd;

endmodule

// File: rtl/hwrandom_uart_array.sv
// Entropy output stage: repetition-count health test, byte assembly and
// round-robin dispatch over NUM_PORTS UARTs. Define HWRANDOM_VON_NEUMANN_EN
// to debias the raw stream before assembly.
module hwrandom_uart_array
    import hwrandom_pkg::*;
#(
    parameter int NUM_PORTS  = 1,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hwrandom_uart_array_if.slave  bus
);

    localparam int BAUD_DIV = calcBaudDiv(CLK_FREQ, BAUD);
    localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0] RCT_LIMIT = 8'(RCT_CUTOFF);

    logic                 r_lastBit;
    logic [7:0]           r_runCnt;
    logic                 r_healthFail;
    logic [7:0]           w_nextRun;

    logic                 w_accValid;
    logic                 w_accBit;

    logic [7:0]           r_shift;
    logic [2:0]           r_bitCnt;
    logic [7:0]           r_hold;
    logic                 r_holdValid;
    logic [PTR_W-1:0]     r_ptr;
    logic [31:0]          r_dispWord;

    logic [NUM_PORTS-1:0] w_portIdle;
    logic [NUM_PORTS-1:0] w_load;
    logic [NUM_PORTS-1:0] w_txd;
    logic                 w_ptrIdle;
    logic                 w_dispatch;
    logic                 w_holdFree;
    logic [7:0]           w_newShift;

    always_comb begin
        w_nextRun = r_runCnt;
        if (bus.raw_valid) begin
            if (r_runCnt == 8'd0 || bus.raw_bit != r_lastBit) begin
                w_nextRun = 8'd1;
            end else if (r_runCnt != 8'hFF) begin
                w_nextRun = r_runCnt + 1'b1;
            end
        end
    end

    // The flag is set from the next count so it is visible the cycle after the tripping bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastBit    <= 1'b0;
            r_runCnt     <= '0;
            r_healthFail <= 1'b0;
        end else begin
            if (bus.raw_valid) begin
                r_lastBit <= bus.raw_bit;
                r_runCnt  <= w_nextRun;
            end
            if (w_nextRun >= RCT_LIMIT) begin
                r_healthFail <= 1'b1;
            end
        end
    end

`ifdef HWRANDOM_VON_NEUMANN_EN
    logic r_pairHave;
    logic r_pairFirst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pairHave  <= 1'b0;
            r_pairFirst <= 1'b0;
        end else if (r_healthFail) begin
            r_pairHave  <= 1'b0;
            r_pairFirst <= 1'b0;
        end else if (bus.raw_valid) begin
            r_pairHave <= !r_pairHave;
            if (!r_pairHave) begin
                r_pairFirst <= bus.raw_bit;
            end
        end
    end

    assign w_accValid = bus.raw_valid && r_pairHave && (bus.raw_bit != r_pairFirst) && !r_healthFail;
    assign w_accBit   = r_pairFirst;
`else
    assign w_accValid = bus.raw_valid && !r_healthFail;
    assign w_accBit   = bus.raw_bit;
`endif

    always_comb begin
        w_ptrIdle = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_ptr == PTR_W'(i)) begin
                w_ptrIdle = w_portIdle[i];
            end
        end
    end

    assign w_dispatch = r_holdValid && !r_healthFail && w_ptrIdle;
    // A byte leaving the holding register frees it for a byte completing this same cycle.
    assign w_holdFree = !r_holdValid || w_dispatch;
    assign w_newShift = {w_accBit, r_shift[7:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_hold      <= '0;
            r_holdValid <= 1'b0;
            r_ptr       <= '0;
            r_dispWord  <= '0;
        end else if (r_healthFail) begin
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_hold      <= '0;
            r_holdValid <= 1'b0;
        end else begin
            if (w_dispatch) begin
                r_holdValid <= 1'b0;
                r_dispWord  <= {r_dispWord[23:0], r_hold};
                r_ptr       <= (r_ptr == PTR_W'(NUM_PORTS - 1)) ? '0 : r_ptr + 1'b1;
            end
            if (w_accValid && w_holdFree) begin
                r_shift <= w_newShift;
                if (r_bitCnt == 3'd7) begin
                    r_hold      <= w_newShift;
                    r_holdValid <= 1'b1;
                    r_bitCnt    <= '0;
                end else begin
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gPort
        assign w_load[g] = w_dispatch && (r_ptr == PTR_W'(g));

        hwrandom_uart_tx #(
            .BAUD_DIV (BAUD_DIV)
        ) uTx (
            .clk     (clk),
            .reset_n (reset_n),
            .i_load  (w_load[g]),
            .i_data  (r_hold),
            .o_idle  (w_portIdle[g]),
            .o_txd   (w_txd[g])
        );
    end

    assign bus.TxD         = w_txd;
    assign bus.health_fail = r_healthFail;
    assign bus.disp_word   = r_dispWord;

endmodule

// File: doc/hwrandom_uart_array.md
Name: hwrandom_uart_array

Overview:
- Parametrised successor to the single-core hwrng output stage.
- Takes a raw entropy bit stream from the ring-oscillator sampler and runs a repetition-count health test on it.
- Optionally debiases the stream, packs it into bytes and distributes the bytes round-robin over NUM_PORTS independent 8N1 UART transmitters.
- Exports the last four bytes sent for the hex display.

Parameters:
- NUM_PORTS, 1, number of UART outputs (1..8).
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer floor, must be >= 2).
- RCT_CUTOFF, 32, number of consecutive identical raw bits that trips the health test (2..255).

Ports:
- clk  input  1  single system clock.
- reset_n  input  1  asynchronous active-low reset.
- raw_bit  input  1  sampled entropy bit.
- raw_valid  input  1  raw_bit is valid this cycle (at most one bit per cycle).
- TxD  output  NUM_PORTS  UART serial outputs, idle high.
- health_fail  output  1  sticky repetition-count failure flag.
- disp_word  output  32  last four dispatched bytes, newest in [7:0].

Behaviour:
- Reset values: TxD all 1, health_fail 0, disp_word 0, all counters, assembler and holding register cleared.
- Reset is asynchronous and may occur mid-frame; TxD returns high immediately.
- RCT:
  - Tracks the last raw bit and a saturating run counter; raw bits are counted before debiasing.
  - A differing bit resets the count to 1.
  - When the count reaches RCT_CUTOFF, health_fail rises on the following cycle and stays high until reset.
- Assembler:
  - Accepted bits shift in LSB-first; after 8 bits the byte moves to a one-deep holding register and the bit count wraps to 0.
  - If the holding register is full, accepted bits are dropped and the count is unchanged.
  - On health_fail, the partial byte and holding register are discarded and no further bits are accepted.
- Dispatcher:
  - Pointer ptr starts at 0.
  - When the holding register is full and port ptr is idle, it loads the byte into that port and clears the holding register in the same cycle.
  - It then sets ptr = (ptr+1) mod NUM_PORTS and updates disp_word = {disp_word[23:0], byte}.
  - It never skips a busy port, so output order is deterministic.
  - Holding-register load and dispatch in the same cycle is allowed: the new byte replaces the dispatched one.
- UART port (per instance):
  - States IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state lasts BAUD_DIV cycles; DATA lasts 8*BAUD_DIV cycles, LSB first.
  - TxD drives the start bit (0) on the cycle after load; a frame is exactly 10*BAUD_DIV cycles.
  - The port reports idle and can accept a new byte in the first cycle it is back in IDLE.
  - Ports already mid-frame when health_fail rises finish their frame.

Optional Feature:
- Macro: HWRANDOM_VON_NEUMANN_EN.
- Defined:
  - Raw bits are paired (first, second) in arrival order.
  - Pair 01 emits 0 and pair 10 emits 1; pairs 00 and 11 emit nothing.
  - The pair state resets on reset_n and on health_fail.
- Undefined: every raw_valid bit is accepted directly.
- The RCT sees the raw stream in both cases.

Decomposition:
- Package hwrandom_pkg holds:
  - the UART state enum (IDLE, START, DATA, STOP);
  - the frame length constant (10);
  - the BAUD_DIV computation function.
- One sub-module, hwrandom_uart_tx: byte load/idle handshake, baud counter and bit counter.
- It is instantiated NUM_PORTS times by a generate loop.

Test Plan:
- Basic byte and frame (CLK_FREQ=1000, BAUD=100, BAUD_DIV=10, NUM_PORTS=1, macro off):
  - Stimulus: raw bits 1,0,1,0,0,1,0,1.
  - Response: disp_word=0x000000A5.
  - Response: TxD = 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles, starting 2 cycles after the 8th bit.
- Round-robin (NUM_PORTS=2):
  - Stimulus: bytes 0x11, 0x22, 0x33.
  - Response: port0 sends 0x11, port1 sends 0x22, then port0 sends 0x33 after its first frame ends.
  - Response: final disp_word=0x00112233.
- Health test (RCT_CUTOFF=8):
  - Stimulus: eight consecutive 1 bits.
  - Response: health_fail=1 on the cycle after the 8th bit; no start bit ever appears; health_fail stays high.
- Von Neumann (macro on):
  - Stimulus: raw pairs 01,10,00,11, repeated 4 times.
  - Response: accepted bits 0,1 repeated, giving byte 0xAA; health_fail stays 0.
- Back-pressure (NUM_PORTS=1):
  - Stimulus: 24 bits sent back-to-back while port0 is busy.
  - Response: byte 2 waits in the holding register; bits 17-24 are dropped; exactly two frames are sent.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 during the DATA state.
  - Response: TxD=1 the same cycle; disp_word=0; health_fail=0; after release, the next byte goes to port0.
